hex_display_scanner: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode hex display.

---
 rtl/hex_display_scanner_pkg.sv | 29 ++
 rtl/hex_display_scanner_scan_tick_gen.sv | 34 +++
 rtl/hex_display_scanner.sv | 165 ++++++++++++++++
 tb/tb_hex_display_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scanner_pkg.sv
// Shared definitions for the hex display scanner: FSM encoding, default
// timing constants and a constant-width helper.
package hex_display_scanner_pkg;

    // Slot phases: GUARD keeps every enable off, ON lights the active digit.
    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam int DEFAULT_DIGIT_CYC = 50000;
    localparam int DEFAULT_GUARD_CYC = 2;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hex_display_scanner_scan_tick_gen.sv
// Slot timer: counts 0..DIGIT_CYC-1 and flags the last guard cycle and the
// last cycle of each digit slot.
import hex_display_scanner_pkg::*;

module scan_tick_gen #(
    parameter int DIGIT_CYC = DEFAULT_DIGIT_CYC,
    parameter int GUARD_CYC = DEFAULT_GUARD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    output logic guard_end,
    output logic slot_end
);

    localparam int CW = clog2(DIGIT_CYC);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] GUARD_LST = CW'(GUARD_CYC - 1);

    logic [CW-1:0] cnt;

    // Free-running slot counter that wraps at the end of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST_CNT)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign slot_end  = (cnt == LAST_CNT);
    assign guard_end = (cnt == GUARD_LST);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for an N-digit common-anode hex display.
// Holds a double-buffered value, steps through the digits and presents the
// active nibble to an external hex_to_7seg decoder plus active-low enables.
//
// load is a single-cycle strobe with no back-pressure: every cycle it is high
// the value/dp_in pair is captured into the pending buffer (last one wins).
// The pending buffer moves to the display buffer only at frame wrap so a
// frame never shows a mix of two loaded values.
import hex_display_scanner_pkg::*;

module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_CYC  = DEFAULT_DIGIT_CYC,
    parameter int GUARD_CYC  = DEFAULT_GUARD_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_done,
    output logic                    pending,
    output state_t                  dbg_state
);

    localparam int DW = clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    logic                  guard_end;
    logic                  slot_end;
    logic                  frame_wrap;
    state_t                state;
    state_t                state_next;
    logic [DW-1:0]         digit;
    logic [DW-1:0]         digit_next;
    logic [VW-1:0]         disp_buf;
    logic [VW-1:0]         pend_buf;
    logic [VW-1:0]         disp_next;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] disp_dp_next;
    logic                  blank_r;
    logic                  blank_next;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  upper_nz;
    logic [NUM_DIGITS-1:0] an_next;

    scan_tick_gen #(
        .DIGIT_CYC (DIGIT_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .guard_end (guard_end),
        .slot_end  (slot_end)
    );

    assign frame_wrap = slot_end && (digit == LAST_DIGIT);
    assign dbg_state  = state;

    // Slot phase sequencing: leave GUARD after the guard cycles, return at slot end.
    always_comb begin
        state_next = state;
        case (state)
            ST_GUARD: if (guard_end) state_next = ST_ON;
            ST_ON:    if (slot_end)  state_next = ST_GUARD;
            default:  state_next = ST_GUARD;
        endcase
    end

    // Digit index and buffer contents that the next slot will use.
    always_comb begin
        digit_next   = digit;
        disp_next    = disp_buf;
        disp_dp_next = disp_dp;
        if (slot_end)
            digit_next = (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
        if (frame_wrap) begin
            disp_next    = pend_buf;
            disp_dp_next = pend_dp;
        end
    end

    // Nibble/dp selection and leading-zero blank decision for the next slot.
    always_comb begin
        sel_nib  = 4'h0;
        sel_dp   = 1'b0;
        upper_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_next == DW'(k)) begin
                sel_nib = disp_next[4*k +: 4];
                sel_dp  = disp_dp_next[k];
            end
            if ((DW'(k) >= digit_next) && (disp_next[4*k +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
        blank_next = blank_lz && (digit_next != '0) && !upper_nz && !sel_dp;
    end

    // Enable pattern: only the active, unblanked digit goes low, and only in ON.
    always_comb begin
        an_next = '1;
        if ((state_next == ST_ON) && !blank_r) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                if (digit == DW'(k)) an_next[k] = 1'b0;
        end
    end

    // Scan state: FSM, digit index and enable register (reset blanks at once).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_GUARD;
            digit      <= '0;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            digit      <= digit_next;
            an_n       <= an_next;
            frame_done <= frame_wrap;
        end
    end

    // Per-slot outputs latch on GUARD entry so hex_out settles before enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out <= 4'h0;
            dp_n    <= 1'b1;
            blank_r <= 1'b0;
        end else if (slot_end) begin
            hex_out <= sel_nib;
            dp_n    <= blank_next ? 1'b1 : !sel_dp;
            blank_r <= blank_next;
        end
    end

    // Double buffer: commit at frame wrap, a load in that cycle refills pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_buf <= '0;
            disp_dp  <= '0;
            pend_buf <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
        end else begin
            if (frame_wrap) begin
                disp_buf <= pend_buf;
                disp_dp  <= pend_dp;
                pending  <= 1'b0;
            end
            if (load) begin
                pend_buf <= value;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: cycle-by-cycle comparison against a
// time-based reference model (slot and frame derived from elapsed cycles).
import hex_display_scanner_pkg::*;

module tb_hex_display_scanner;

    localparam int N     = 4;
    localparam int D     = 8;
    localparam int G     = 2;
    localparam int FRAME = N * D;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [4*N-1:0]  value = '0;
    logic [N-1:0]    dp_in = '0;
    logic            blank_lz = 1'b0;
    logic [3:0]      hex_out;
    logic [N-1:0]    an_n;
    logic            dp_n;
    logic            frame_done;
    logic            pending;
    state_t          dbg_state;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // reference model state
    int             t;
    logic [15:0]    m_disp;
    logic [3:0]     m_dp;
    logic [15:0]    m_pbuf;
    logic [3:0]     m_pdp;
    logic           m_pflag;
    logic           m_blank;

    hex_display_scanner #(
        .NUM_DIGITS (N),
        .DIGIT_CYC  (D),
        .GUARD_CYC  (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .hex_out    (hex_out),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_done (frame_done),
        .pending    (pending),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic logic is_blank(input int slot, input logic blz);
        logic [15:0] upper;
        upper = m_disp >> (4 * slot);
        return blz && (slot != 0) && (upper == 16'h0) && !m_dp[slot];
    endfunction

    // model: elapsed cycles since reset decide slot/frame; buffers follow the rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_disp = '0; m_dp = '0; m_pbuf = '0; m_pdp = '0;
            m_pflag = 1'b0; m_blank = 1'b0;
        end else begin
            if (t % FRAME == FRAME - 1) begin
                m_disp = m_pbuf;
                m_dp = m_pdp;
                m_pflag = 1'b0;
            end
            if (load) begin
                m_pbuf = value;
                m_pdp = dp_in;
                m_pflag = 1'b1;
            end
            if (t % D == D - 1)
                m_blank = is_blank(((t + 1) / D) % N, blank_lz);
            t = t + 1;
        end
    end

    // scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            int pos;
            int slot;
            logic [3:0] e_an;
            logic [3:0] one;
            logic [15:0] sh;
            pos  = t % D;
            slot = (t / D) % N;
            one  = 4'b0001 << slot;
            e_an = (pos < G || m_blank) ? 4'hF : ~one;
            sh   = m_disp >> (4 * slot);
            chk("an_n", 32'(an_n), 32'(e_an));
            chk("hex_out", 32'(hex_out), 32'(sh[3:0]));
            chk("dp_n", 32'(dp_n), 32'(m_blank ? 1'b1 : !m_dp[slot]));
            chk("frame_done", 32'(frame_done), 32'((t > 0) && (t % FRAME == 0)));
            chk("pending", 32'(pending), 32'(m_pflag));
            chk("state", 32'(dbg_state), 32'((pos < G) ? ST_GUARD : ST_ON));
            chk("an_onehot0", 32'($onehot0(~an_n)), 32'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        load = 1'b1; value = v; dp_in = dp;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int m, input int target);
        int n;
        n = 0;
        while ((t % m) != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((t % m) != target) chk("wait_phase_timeout", 32'(t % m), 32'(target));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_an"}, 32'(an_n), 32'hF);
        chk({tag, "_dp"}, 32'(dp_n), 32'd1);
        chk({tag, "_hex"}, 32'(hex_out), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_pend"}, 32'(pending), 32'd0);
    endtask

    initial begin
        // reset and release away from the rising edge
        cycles(3);
        reset_checks("rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        reset_checks("rel");
        chk_en = 1'b1;
        cycles(40);

        // plain load, no blanking
        do_load(16'h1A2F, 4'b0000);
        chk("pend_after_load", 32'(pending), 32'd1);
        cycles(70);

        // leading-zero blanking on and off
        blank_lz = 1'b1;
        do_load(16'h0030, 4'b0000);
        cycles(70);
        blank_lz = 1'b0;
        cycles(40);

        // two loads in one frame: last wins
        wait_phase(FRAME, 5);
        do_load(16'h1111, 4'b0000);
        cycles(8);
        do_load(16'h2222, 4'b0000);
        cycles(70);

        // load on the commit cycle leaves pending set
        wait_phase(FRAME, 10);
        do_load(16'h4444, 4'b0000);
        wait_phase(FRAME, FRAME - 1);
        do_load(16'h3333, 4'b0000);
        chk("pend_commit_load", 32'(pending), 32'd1);
        cycles(70);

        // decimal point keeps an otherwise blanked digit visible
        blank_lz = 1'b1;
        do_load(16'h0000, 4'b0100);
        cycles(70);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 9) == 0);
            value = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            @(negedge clk);
        end
        load = 1'b0;

        // asynchronous reset while a digit is lit
        blank_lz = 1'b0;
        cycles(2 * FRAME);
        wait_phase(D, 4);
        chk("pre_rst_lit", 32'($countones(~an_n)), 32'd1);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 reset_checks("async");
        cycles(2);
        reset_checks("held");
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
